// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared types and constants for the instruction-memory boot loader
// Holds the 3-bit loader state encoding, the frame-format constants and the default sizes.
// The top module and the byte packer both import this package.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam int ADDR_W_DEFAULT    = 10;
    localparam int MAX_WORDS_DEFAULT = 1024;
    localparam int LEN_W             = 16;     // width of the frame's word-count field
    localparam logic [1:0] LAST_BYTE_IDX = 2'd3; // byte 3 completes a little-endian word

    // States in which the loader still consumes stream bytes.
    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// rtl/imem_boot_loader_byte_packer.sv - assembles four stream bytes into a little-endian 32-bit word
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear_i           drop any partially assembled word (restart)
//   byte_valid_i      a payload byte is transferred this cycle
//   byte_data_i       the payload byte
//   byte_idx_o        position (0..3) the next byte will take in the word
//   word_o            assembled word, stable during the word_valid_o cycle
//   word_valid_o      one-cycle pulse in the cycle after the 4th byte
module imem_boot_loader_byte_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic [1:0]  byte_idx_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    // Bytes shift in from the top so byte 0 ends up in bits [7:0].
    // The word register only moves on a new byte, so it holds steady through
    // the write pulse even if the following byte arrives in that same cycle.
    // clear_i leaves a pending word_valid pulse alone so that write completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= byte_valid_i && !clear_i && (idx_q == LAST_BYTE_IDX);
            if (clear_i) begin
                idx_q <= 2'd0;
            end else if (byte_valid_i) begin
                word_q <= {byte_data_i, word_q[31:8]};
                idx_q  <= idx_q + 2'd1;
            end
        end
    end

    assign byte_idx_o   = idx_q;
    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a length-prefixed, XOR-checked byte image into instruction memory
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   restart           pulse: abandon current state and await a new image
//   rx_valid/rx_data  incoming byte stream; rx_ready accepts it
//   imem_we/addr/wdata  one-cycle word write into instruction memory
//   core_rst_n        core reset, released only once the image is verified
//   boot_done         image loaded and checksum matched
//   boot_err          length out of range or checksum mismatch
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_done,
    output logic              boot_err
);

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   word_cnt_q;
    logic [7:0]         csum_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               core_rst_n_q;
    logic               boot_done_q;
    logic               boot_err_q;

    logic               transfer_d;
    logic [LEN_W-1:0]   len_d;
    logic [1:0]         pk_idx;
    logic [31:0]        pk_word;
    logic               pk_word_valid;

    // Gated by rst_n so the stream is refused while reset is held.
    assign rx_ready   = rst_n & accepts_bytes(state_q) & ~restart;
    assign transfer_d = rx_valid & rx_ready;
    assign len_d      = {rx_data, len_q[7:0]};

    imem_boot_loader_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (restart),
        .byte_valid_i (transfer_d && (state_q == ST_DATA)),
        .byte_data_i  (rx_data),
        .byte_idx_o   (pk_idx),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LEN_LO;
            len_q        <= '0;
            word_cnt_q   <= '0;
            csum_q       <= 8'd0;
            addr_q       <= '0;
            core_rst_n_q <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
        end else if (restart) begin
            state_q      <= ST_LEN_LO;
            len_q        <= '0;
            word_cnt_q   <= '0;
            csum_q       <= 8'd0;
            // A write already on the bus keeps its address until it completes.
            if (!pk_word_valid) begin
                addr_q <= '0;
            end
            core_rst_n_q <= 1'b0;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
        end else if (transfer_d) begin
            case (state_q)
                ST_LEN_LO: begin
                    len_q[7:0] <= rx_data;
                    state_q    <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    len_q <= len_d;
                    if (len_d == '0) begin
                        state_q <= ST_CHECK;
                    end else if (len_d > LEN_W'(MAX_WORDS)) begin
                        state_q    <= ST_ERROR;
                        boot_err_q <= 1'b1;
                    end else begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    csum_q <= csum_q ^ rx_data;
                    // Address is latched with the completing byte so it is
                    // already registered when the packer raises the write.
                    if (pk_idx == LAST_BYTE_IDX) begin
                        addr_q     <= word_cnt_q[ADDR_W-1:0];
                        word_cnt_q <= word_cnt_q + 1'b1;
                        if (word_cnt_q == len_q - 1'b1) begin
                            state_q <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (rx_data == csum_q) begin
                        state_q      <= ST_DONE;
                        core_rst_n_q <= 1'b1;
                        boot_done_q  <= 1'b1;
                    end else begin
                        state_q    <= ST_ERROR;
                        boot_err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we    = pk_word_valid;
    assign imem_addr  = addr_q;
    assign imem_wdata = pk_word;
    assign core_rst_n = core_rst_n_q;
    assign boot_done  = boot_done_q;
    assign boot_err   = boot_err_q;

endmodule
